// File: rtl/mult_op_sequencer.sv
// Operand-issue and result-capture sequencer for the 8x8 serial shift-add multiplier.
// Buffers one operand pair, launches the multiplier, captures its product and guards against a hang.
`timescale 1ns/1ps
module mult_op_sequencer #(
  parameter int unsigned TIMEOUT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ready,
  input  logic [15:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        busy,
  output logic        err,
  output logic [7:0]  ops_done
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

  state_t         r_state;
  logic           r_buf_valid;
  logic [DW-1:0]  r_buf_a;
  logic [DW-1:0]  r_buf_b;
  logic [CW-1:0]  r_tcnt;

  logic           w_accept;
  logic           w_out_free;
  logic           w_capture;
  logic           w_timeout;
  logic [CW-1:0]  w_tcnt_inc;

  assign w_accept   = in_valid && !r_buf_valid;
  assign w_out_free = !out_valid || out_ready;
  assign w_capture  = (r_state == S_RUN) && mul_ready && w_out_free;
  assign w_tcnt_inc = r_tcnt + CW'(1);
  assign w_timeout  = (r_state == S_RUN) && !mul_ready && (w_tcnt_inc == CW'(TIMEOUT));

  // Flop-only decodes: no combinational path from any input.
  assign in_ready = !r_buf_valid;
  assign busy     = (r_state != S_IDLE) || r_buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_a     <= '0;
      r_buf_b     <= '0;
      r_tcnt      <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      err         <= 1'b0;
      ops_done    <= '0;
    end else begin
      mul_start <= 1'b0;

      // Operand buffer: a same-edge accept wins over the LAUNCH release.
      if (w_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_a     <= in_a;
        r_buf_b     <= in_b;
      end else if (r_state == S_LAUNCH) begin
        r_buf_valid <= 1'b0;
      end

      // Output register: a same-edge capture keeps out_valid set.
      if (w_capture) begin
        out_valid   <= 1'b1;
        out_product <= PW'(mul_product);
        ops_done    <= ops_done + CW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_buf_valid) begin
            r_state   <= S_LAUNCH;
            mul_start <= 1'b1;
            mul_a     <= r_buf_a;
            mul_b     <= r_buf_b;
          end
        end
        S_LAUNCH: begin
          r_tcnt  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (mul_ready) begin
            // A blocked output leaves the product parked in the multiplier.
            if (w_out_free) begin
              if (r_buf_valid) begin
                r_state   <= S_LAUNCH;
                mul_start <= 1'b1;
                mul_a     <= r_buf_a;
                mul_b     <= r_buf_b;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else if (w_timeout) begin
            err     <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Directed bench for mult_op_sequencer with a behavioural 8-cycle multiplier and a hang stub.
`timescale 1ns/1ps
module tb_mult_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_ready;
  logic [15:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        busy;
  logic        err;
  logic [7:0]  ops_done;

  int checks = 0;
  int errors = 0;
  int n;

  // Multiplier model: loads on start, raises ready 8 edges later and holds it.
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_cnt = '0;
  logic        m_rdy = 1'b0;
  logic [15:0] m_prod = '0;
  logic        stub = 1'b0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_cnt <= 4'd8;
      m_rdy <= 1'b0;
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_rdy  <= 1'b1;
        m_prod <= 16'(m_a) * 16'(m_b);
      end
    end
  end

  assign mul_ready   = stub ? 1'b0 : m_rdy;
  assign mul_product = m_prod;

  always #5 clk = ~clk;

  mult_op_sequencer #(.TIMEOUT(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .err(err), .ops_done(ops_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid, bounded; returns the edge index counted from start.
  task automatic wait_out(input int start, output int edges);
    edges = start;
    while (!out_valid && edges < start + 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_in_ready"},  32'(in_ready),    32'd1);
    chk({pfx, "_busy"},      32'(busy),        32'd0);
    chk({pfx, "_err"},       32'(err),         32'd0);
    chk({pfx, "_ops"},       32'(ops_done),    32'd0);
    chk({pfx, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({pfx, "_out_prod"},  32'(out_product), 32'd0);
    chk({pfx, "_mul_start"}, 32'(mul_start),   32'd0);
    chk({pfx, "_mul_a"},     32'(mul_a),       32'd0);
    chk({pfx, "_mul_b"},     32'(mul_b),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("rst");

    // Single op 13x11.
    in_a = 8'd13; in_b = 8'd11; in_valid = 1'b1;
    tick();                                   // E0 accept
    in_valid = 1'b0;
    chk("single_in_ready_full", 32'(in_ready), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    tick();                                   // E1 LAUNCH
    chk("single_mul_start", 32'(mul_start), 32'd1);
    chk("single_mul_a", 32'(mul_a), 32'd13);
    chk("single_mul_b", 32'(mul_b), 32'd11);
    wait_out(1, n);
    chk("single_latency", 32'(n), 32'd11);
    chk("single_product", 32'(out_product), 32'h008F);
    chk("single_ops", 32'(ops_done), 32'd1);
    tick();
    chk("single_out_drain", 32'(out_valid), 32'd0);

    // Extremes back-to-back: 255x255 then 0x200.
    in_a = 8'd255; in_b = 8'd255; in_valid = 1'b1;
    tick();                                   // E0
    in_a = 8'd0; in_b = 8'd200;
    chk("b2b_full_e0", 32'(in_ready), 32'd0);
    tick();                                   // E1
    chk("b2b_full_e1", 32'(in_ready), 32'd0);
    tick();                                   // E2 buffer released
    chk("b2b_free_e2", 32'(in_ready), 32'd1);
    tick();                                   // E3 second accept
    in_valid = 1'b0;
    chk("b2b_full_e3", 32'(in_ready), 32'd0);
    wait_out(3, n);
    chk("b2b_first_edge", 32'(n), 32'd11);
    chk("b2b_first_prod", 32'(out_product), 32'hFE01);
    chk("b2b_full_e11", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_free_e12", 32'(in_ready), 32'd1);
    chk("b2b_gap_valid", 32'(out_valid), 32'd0);
    wait_out(12, n);
    chk("b2b_second_edge", 32'(n), 32'd21);
    chk("b2b_second_prod", 32'(out_product), 32'h0000);
    chk("b2b_ops", 32'(ops_done), 32'd3);
    tick();

    // Downstream stall across a second completion.
    out_ready = 1'b0;
    in_a = 8'd3; in_b = 8'd3; in_valid = 1'b1;
    tick();                                   // E0
    in_a = 8'd1; in_b = 8'd2;
    tick(); tick(); tick();                   // E3 second accept
    in_valid = 1'b0;
    for (int i = 4; i <= 24; i++) tick();     // E24
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_held_prod", 32'(out_product), 32'h0009);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_ops", 32'(ops_done), 32'd4);
    out_ready = 1'b1;
    tick();                                   // E25 capture on release
    chk("stall_release_valid", 32'(out_valid), 32'd1);
    chk("stall_release_prod", 32'(out_product), 32'h0002);
    chk("stall_release_ops", 32'(ops_done), 32'd5);
    tick();
    chk("stall_drain", 32'(out_valid), 32'd0);
    chk("stall_idle", 32'(busy), 32'd0);

    // Timeout with a hung multiplier.
    stub = 1'b1;
    in_a = 8'd5; in_b = 8'd5; in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    for (int i = 1; i <= 13; i++) tick();     // E13
    chk("to_err_before", 32'(err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    tick();                                   // E14 abort
    chk("to_err", 32'(err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_out_valid", 32'(out_valid), 32'd0);
    chk("to_ops", 32'(ops_done), 32'd5);
    stub = 1'b0;
    in_a = 8'd7; in_b = 8'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(0, n);
    chk("to_next_latency", 32'(n), 32'd11);
    chk("to_next_prod", 32'(out_product), 32'h002A);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_next_ops", 32'(ops_done), 32'd6);
    tick();

    // Reset four cycles after mul_start.
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) tick();      // E5
    rst = 1'b1;
    tick();                                   // E6 reset sampled
    rst = 1'b0;
    check_reset_values("midrst");
    in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(0, n);
    chk("midrst_latency", 32'(n), 32'd11);
    chk("midrst_prod", 32'(out_product), 32'h003F);
    chk("midrst_ops", 32'(ops_done), 32'd1);
    tick();

    // Counter wrap: 255 more ops bring ops_done from 1 back to 0.
    for (int i = 0; i < 255; i++) begin
      in_a = 8'(i); in_b = 8'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(0, n);
      if (i == 253) chk("wrap_ops_255", 32'(ops_done), 32'd255);
      tick();
    end
    chk("wrap_ops_0", 32'(ops_done), 32'd0);
    chk("wrap_last_prod", 32'(out_product), 32'h01FC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
